crank_wheel_gen: RTL



---
 rtl/crank_gen_pkg.sv | 18 +
 rtl/crank_gen_regs.sv | 78 +++++++
 rtl/crank_wheel_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/crank_gen_pkg.sv
// Shared constants for the crank-wheel emulator: register map, GCR bit
// positions and the generator state encoding.
package crank_gen_pkg;

  localparam int unsigned ADDR_GCR    = 0;
  localparam int unsigned ADDR_PER_LO = 1;
  localparam int unsigned ADDR_PER_HI = 2;
  localparam int unsigned ADDR_DUTY   = 3;

  localparam int unsigned GCR_EN_BIT  = 0;
  localparam int unsigned GCR_INV_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/crank_gen_regs.sv
// Host-visible register file for the crank-wheel emulator with a
// registered read port; a same-cycle read returns the pre-write value.
module crank_gen_regs
  import crank_gen_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ssram_we,
  input  logic                    ssram_re,
  input  logic [ADDR_WIDTH-1:0]   ssram_addr,
  input  logic [15:0]             ssram_wdata,
  output logic [15:0]             ssram_rdata,
  output logic                    en,
  output logic                    inv,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic [15:0]             duty
);

  localparam int HI_W = PERIOD_WIDTH - 16;

  logic        sel_gcr;
  logic        sel_per_lo;
  logic        sel_per_hi;
  logic        sel_duty;
  logic [31:0] period_ext;
  logic [15:0] rd_mux;

  assign sel_gcr    = (ssram_addr == ADDR_WIDTH'(ADDR_GCR));
  assign sel_per_lo = (ssram_addr == ADDR_WIDTH'(ADDR_PER_LO));
  assign sel_per_hi = (ssram_addr == ADDR_WIDTH'(ADDR_PER_HI));
  assign sel_duty   = (ssram_addr == ADDR_WIDTH'(ADDR_DUTY));

  // Zero-extended so bits above PERIOD_WIDTH read back as 0 in PER_HI
  assign period_ext = 32'(period);

  always_comb begin
    rd_mux = '0;
    if (sel_gcr) begin
      rd_mux[GCR_EN_BIT]  = en;
      rd_mux[GCR_INV_BIT] = inv;
    end else if (sel_per_lo) begin
      rd_mux = period_ext[15:0];
    end else if (sel_per_hi) begin
      rd_mux = period_ext[31:16];
    end else if (sel_duty) begin
      rd_mux = duty;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en     <= 1'b0;
      inv    <= 1'b0;
      period <= '0;
      duty   <= '0;
    end else if (ssram_we) begin
      if (sel_gcr) begin
        en  <= ssram_wdata[GCR_EN_BIT];
        inv <= ssram_wdata[GCR_INV_BIT];
      end
      if (sel_per_lo) period[15:0]             <= ssram_wdata;
      if (sel_per_hi) period[PERIOD_WIDTH-1:16] <= ssram_wdata[HI_W-1:0];
      if (sel_duty)   duty                     <= ssram_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ssram_rdata <= '0;
    end else if (ssram_re) begin
      ssram_rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// Missing-tooth trigger-wheel emulator: drives a VR-style pulse train whose
// tooth period and duty are reloaded from the register file at each tooth.
module crank_wheel_gen
  import crank_gen_pkg::*;
#(
  parameter int TOOTH_COUNT  = 60,
  parameter int GAP_TEETH    = 2,
  parameter int PERIOD_WIDTH = 24,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ssram_we,
  input  logic                           ssram_re,
  input  logic [ADDR_WIDTH-1:0]          ssram_addr,
  input  logic [15:0]                    ssram_wdata,
  output logic [15:0]                    ssram_rdata,
  output logic                           vr_out,
  output logic [$clog2(TOOTH_COUNT)-1:0] tooth_num,
  output logic                           gap,
  output logic                           rev_pulse
);

  localparam int TW = $clog2(TOOTH_COUNT);

  function automatic logic [PERIOD_WIDTH-1:0] clamp_period(
    input logic [PERIOD_WIDTH-1:0] p
  );
    return (p < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : p;
  endfunction

  // Keeps at least one low cycle per tooth; p is already clamped to >= 2
  function automatic logic [PERIOD_WIDTH-1:0] clamp_duty(
    input logic [15:0]             d,
    input logic [PERIOD_WIDTH-1:0] p
  );
    logic [PERIOD_WIDTH-1:0] dx;
    dx = PERIOD_WIDTH'(d);
    return (dx >= p) ? (p - PERIOD_WIDTH'(1)) : dx;
  endfunction

  logic                    en;
  logic                    inv;
  logic [PERIOD_WIDTH-1:0] period;
  logic [15:0]             duty;

  crank_gen_regs #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .ssram_we    (ssram_we),
    .ssram_re    (ssram_re),
    .ssram_addr  (ssram_addr),
    .ssram_wdata (ssram_wdata),
    .ssram_rdata (ssram_rdata),
    .en          (en),
    .inv         (inv),
    .period      (period),
    .duty        (duty)
  );

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] per_sh;
  logic [PERIOD_WIDTH-1:0] duty_sh;
  logic [PERIOD_WIDTH-1:0] per_ld;
  logic [PERIOD_WIDTH-1:0] duty_ld;

  logic [PERIOD_WIDTH-1:0] phase_p0;
  logic [TW-1:0]           tooth_p0;
  logic                    vld_p0;
  logic                    wrap_p0;
  logic                    is_gap_p0;
  logic                    last_tooth_p0;

  logic                    vr_p1;
  logic                    gap_p1;
  logic                    rev_p1;

  assign per_ld  = clamp_period(period);
  assign duty_ld = clamp_duty(duty, per_ld);

  assign vld_p0        = (state == RUN) && en;
  assign wrap_p0       = (phase_p0 == per_sh - PERIOD_WIDTH'(1));
  assign is_gap_p0     = (tooth_p0 >= TW'(TOOTH_COUNT - GAP_TEETH));
  assign last_tooth_p0 = (tooth_p0 == TW'(TOOTH_COUNT - 1));

  // Stage p0: state, shadows and phase/tooth counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      per_sh   <= '0;
      duty_sh  <= '0;
      phase_p0 <= '0;
      tooth_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase_p0 <= '0;
          tooth_p0 <= '0;
          if (en) begin
            state   <= RUN;
            per_sh  <= per_ld;
            duty_sh <= duty_ld;
          end
        end
        RUN: begin
          if (!en) begin
            state    <= IDLE;
            phase_p0 <= '0;
            tooth_p0 <= '0;
          end else if (wrap_p0) begin
            phase_p0 <= '0;
            tooth_p0 <= last_tooth_p0 ? '0 : tooth_p0 + TW'(1);
            per_sh   <= per_ld;
            duty_sh  <= duty_ld;
          end else begin
            phase_p0 <= phase_p0 + PERIOD_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: registered waveform, one cycle behind the counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vr_p1  <= 1'b0;
      gap_p1 <= 1'b0;
      rev_p1 <= 1'b0;
    end else if (vld_p0) begin
      vr_p1  <= inv ^ (!is_gap_p0 && (phase_p0 < duty_sh));
      gap_p1 <= is_gap_p0;
      rev_p1 <= (phase_p0 == '0) && (tooth_p0 == '0);
    end else begin
      vr_p1  <= inv;
      gap_p1 <= 1'b0;
      rev_p1 <= 1'b0;
    end
  end

  assign vr_out    = vr_p1;
  assign gap       = gap_p1;
  assign rev_pulse = rev_p1;
  assign tooth_num = tooth_p0;

endmodule
